stack_node: RTL and testbench

//  TIS-100 stack memory node for the compiled core grid: a LIFO of signed words shared by NPORTS neighbouring cores.

---
 rtl/tis_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 47 ++++
 rtl/stack_node.sv | 105 ++++++++++
 tb/tb_stack_node.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tis_pkg.sv
// Shared TIS-100 grid types: word format, accumulator range
// and the neighbour port numbering used by grid nodes.
package tis_pkg;

  localparam int WORD_W = 11;

  typedef logic signed [WORD_W-1:0] word_t;

  localparam int ACC_MAX = 999;
  localparam int ACC_MIN = -999;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2,
    DOWN  = 2'd3
  } port_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or
// after the pointer; the pointer moves past the winner on a grant.
module rr_arbiter
  import tis_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         valid
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx;
  int            j;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    ptr_d = ptr_q;
    idx   = '0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_q) + i;
      if (j >= N) j = j - N;
      idx = PW'(j);
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        grant[idx] = 1'b1;
        ptr_d      = (j == N - 1) ? '0 : PW'(j + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/stack_node.sv
// Shared LIFO grid node: neighbours push/pop words over a
// one-cycle ack handshake, one operation per clock, round-robin.
module stack_node
  import tis_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int DEPTH  = 15,
  parameter int NPORTS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NPORTS-1:0]             write,
  input  logic [NPORTS-1:0][WIDTH-1:0]  in,
  output logic [NPORTS-1:0]             wready,
  input  logic [NPORTS-1:0]             read,
  output logic [NPORTS-1:0]             rready,
  output logic [NPORTS-1:0][WIDTH-1:0]  out,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  logic [WIDTH-1:0] mem_q [0:DEPTH-1];

  logic [CW-1:0]                 count_q, count_d;
  logic [NPORTS-1:0]             wready_q, wready_d;
  logic [NPORTS-1:0]             rready_q, rready_d;
  logic [NPORTS-1:0][WIDTH-1:0]  out_q, out_d;

  logic              full, empty;
  logic [NPORTS-1:0] elig, grant;
  logic              gnt_v;
  logic [PW-1:0]     gidx;
  logic              do_push, do_pop;
  logic [CW-1:0]     pop_idx;

  // Ports being acked this cycle are masked so they cannot win twice.
  always_comb begin
    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);
    elig  = ((write & {NPORTS{!full}}) | (read & {NPORTS{!empty}}))
          & ~wready_q & ~rready_q;
  end

  rr_arbiter #(.N(NPORTS)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (elig),
    .grant (grant),
    .valid (gnt_v)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (grant[i]) gidx = PW'(i);
    end
    do_push  = gnt_v && (|(grant & write)) && !full;
    do_pop   = gnt_v && !do_push;
    pop_idx  = count_q - CW'(1);
    count_d  = count_q;
    wready_d = '0;
    rready_d = '0;
    out_d    = out_q;
    unique case (1'b1)
      do_push: begin
        count_d  = count_q + CW'(1);
        wready_d = grant;
      end
      do_pop: begin
        count_d     = pop_idx;
        rready_d    = grant;
        out_d[gidx] = mem_q[pop_idx];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      wready_q <= '0;
      rready_q <= '0;
      out_q    <= '0;
    end else begin
      count_q  <= count_d;
      wready_q <= wready_d;
      rready_q <= rready_d;
      out_q    <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_q[count_q] <= in[gidx];
    end
  end

  assign wready = wready_q;
  assign rready = rready_q;
  assign out    = out_q;
  assign count  = count_q;

endmodule

// File: tb/tb_stack_node.sv
// Scoreboard bench for stack_node: drivers queue expected acks,
// a negedge monitor pops and compares them as the DUT acks.
module tb_stack_node;
  import tis_pkg::*;

  localparam int W  = 11;
  localparam int D  = 15;
  localparam int NP = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NP-1:0]         wr  = '0;
  logic [NP-1:0]         rd  = '0;
  logic [NP-1:0][W-1:0]  din = '0;
  logic [NP-1:0]         wready, rready;
  logic [NP-1:0][W-1:0]  dout;
  logic [3:0]            count;

  stack_node #(.WIDTH(W), .DEPTH(D), .NPORTS(NP)) dut (
    .clk    (clk),
    .rst    (rst),
    .write  (wr),
    .in     (din),
    .wready (wready),
    .read   (rd),
    .rready (rready),
    .out    (dout),
    .count  (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int port;
    bit is_pop;
    int data;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   ack_w [NP];
  int   ack_r [NP];
  int   last_w[NP];
  int   last_r[NP];
  logic [NP-1:0] prev_w = '0;
  logic [NP-1:0] prev_r = '0;

  initial begin
    for (int i = 0; i < NP; i++) begin
      ack_w[i] = 0; ack_r[i] = 0; last_w[i] = 0; last_r[i] = 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sb_take(input int p, input bit is_pop);
    int k;
    k = -1;
    for (int i = 0; i < sb_q.size(); i++) begin
      if (k < 0 && sb_q[i].port == p) k = i;
    end
    if (k < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_ack: port %0d pop=%0d got ack expected none", p, is_pop);
    end else begin
      chk("ack_kind", int'(is_pop), int'(sb_q[k].is_pop));
      if (is_pop) chk("pop_data", int'($signed(dout[p])), sb_q[k].data);
      sb_q.delete(k);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int p = 0; p < NP; p++) begin
      if (wready[p] === 1'b1) begin
        ack_w[p]++;
        last_w[p] = cyc;
        chk("wready_single", int'(prev_w[p]), 0);
        sb_take(p, 1'b0);
      end
      if (rready[p] === 1'b1) begin
        ack_r[p]++;
        last_r[p] = cyc;
        chk("rready_single", int'(prev_r[p]), 0);
        sb_take(p, 1'b1);
      end
    end
    if ((wready | rready) != '0)
      chk("one_ack", $countones({wready, rready}), 1);
    prev_w = wready;
    prev_r = rready;
  end

  function automatic int total_acks();
    int s;
    s = 0;
    for (int i = 0; i < NP; i++) s += ack_w[i] + ack_r[i];
    return s;
  endfunction

  // Starts and ends 1 time unit after a rising edge.
  task automatic push(input int p, input int v, input int bound);
    bit acked;
    sb_q.push_back('{port: p, is_pop: 1'b0, data: v});
    din[p] = W'(v);
    wr[p]  = 1'b1;
    acked  = 1'b0;
    for (int i = 0; i < bound && !acked; i++) begin
      @(negedge clk);
      if (wready[p] === 1'b1) acked = 1'b1;
    end
    @(posedge clk);
    #1 wr[p] = 1'b0;
    chk("push_acked", int'(acked), 1);
  endtask

  task automatic pop(input int p, input int exp, input int bound, input bit exp_ack);
    bit acked;
    if (exp_ack) sb_q.push_back('{port: p, is_pop: 1'b1, data: exp});
    rd[p] = 1'b1;
    acked = 1'b0;
    for (int i = 0; i < bound && !acked; i++) begin
      @(negedge clk);
      if (rready[p] === 1'b1) acked = 1'b1;
    end
    @(posedge clk);
    #1 rd[p] = 1'b0;
    chk("pop_acked", int'(acked), int'(exp_ack));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int base;
    int w0;

    // 1: reset state and idle
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_wready", int'(wready), 0);
    chk("rst_rready", int'(rready), 0);
    for (int p = 0; p < NP; p++) chk("rst_out", int'(dout[p]), 0);
    base = total_acks();
    repeat (3) @(negedge clk);
    chk("idle_no_ack", total_acks(), base);
    @(posedge clk);
    #1;

    // 2: LIFO order
    push(UP, 1, 10);
    push(UP, 2, 10);
    push(UP, ACC_MIN, 10);
    chk("lifo_count3", int'(count), 3);
    pop(DOWN, -999, 10, 1'b1);
    pop(DOWN, 2, 10, 1'b1);
    pop(DOWN, 1, 10, 1'b1);
    chk("lifo_count0", int'(count), 0);

    // 3: full stall, then pop frees a slot for the stalled push
    for (int v = 0; v < D; v++) push(LEFT, v, 10);
    chk("full_count", int'(count), 15);
    w0 = ack_w[LEFT];
    fork
      push(LEFT, 99, 40);
      begin
        repeat (5) @(negedge clk);
        chk("full_stall", ack_w[LEFT], w0);
        @(posedge clk);
        #1;
        pop(RIGHT, 14, 10, 1'b1);
      end
    join
    chk("full_ack_gap", last_w[LEFT] - last_r[RIGHT], 1);
    chk("full_count2", int'(count), 15);
    pop(RIGHT, 99, 10, 1'b1);
    for (int v = 13; v >= 0; v--) pop(RIGHT, v, 10, 1'b1);
    chk("drain_count", int'(count), 0);

    // 4: empty stall, then a push unblocks the pop
    w0 = ack_r[RIGHT];
    fork
      pop(RIGHT, 7, 40, 1'b1);
      begin
        repeat (5) @(negedge clk);
        chk("empty_stall", ack_r[RIGHT], w0);
        @(posedge clk);
        #1;
        push(UP, 7, 10);
      end
    join
    chk("empty_ack_gap", last_r[RIGHT] - last_w[UP], 1);
    chk("empty_count", int'(count), 0);

    // 5: four simultaneous pushes from a fresh pointer
    do_reset();
    fork
      push(UP, 10, 20);
      push(LEFT, 11, 20);
      push(RIGHT, 12, 20);
      push(DOWN, 13, 20);
    join
    chk("cont_gap01", last_w[LEFT] - last_w[UP], 1);
    chk("cont_gap12", last_w[RIGHT] - last_w[LEFT], 1);
    chk("cont_gap23", last_w[DOWN] - last_w[RIGHT], 1);
    chk("cont_count", int'(count), 4);
    pop(DOWN, 13, 10, 1'b1);
    pop(DOWN, 12, 10, 1'b1);
    pop(DOWN, 11, 10, 1'b1);
    pop(DOWN, 10, 10, 1'b1);

    // 6: reset lands on the grant edge of a push
    push(UP, 5, 10);
    push(UP, 6, 10);
    din[UP] = W'(7);
    wr[UP]  = 1'b1;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    wr[UP]  = 1'b0;
    @(negedge clk);
    chk("rst_mid_wready", int'(wready[UP]), 0);
    chk("rst_mid_count", int'(count), 0);
    @(posedge clk);
    #1;
    pop(DOWN, 0, 5, 1'b0);
    chk("rst_mid_count2", int'(count), 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got stuck expected completion");
    $fatal(1, "timeout");
  end

endmodule
